// File: rtl/boot_loader_if.sv
// ============================================================================
// Module  : boot_loader_if
// Brief   : Byte-stream input, memory write port and status bundle of the
//           boot loader; slave = loader side, master = source/memory side.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface boot_loader_if #(
    parameter int AW = 12
) ();
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic          mem_wen;
    logic          mem_rdy;
    logic          enable;
    logic          err;
    logic [31:0]   boot_sum;

    modport slave (
        input  in_data, in_valid, in_last, mem_rdy,
        output in_ready, mem_addr, mem_data, mem_wen, enable, err, boot_sum
    );

    modport master (
        output in_data, in_valid, in_last, mem_rdy,
        input  in_ready, mem_addr, mem_data, mem_wen, enable, err, boot_sum
    );
endinterface

`default_nettype wire

// File: rtl/boot_loader.sv
// ============================================================================
// Module  : boot_loader
// Brief   : Packs a little-endian byte stream into 32-bit words, writes them
//           to memory, then raises the CPU run enable. Optional image
//           checksum enabled by macro BOOT_LOADER_CHECKSUM_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module boot_loader #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  wire logic     clk,
    input  wire logic     rst,
    boot_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Index is one bit wider than the address so it can reach DEPTH == 2^AW
    localparam logic [AW:0] c_DEPTH_IDX = (AW+1)'(DEPTH);

    state_t        r_state;
    state_t        w_next;

    logic [1:0]    r_lane;
    logic [31:0]   r_word;
    logic [AW:0]   r_idx;
    logic          r_last;
    logic          r_err;
    logic          r_in_ready;
    logic          r_mem_wen;
    logic          r_enable;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_mem_data;

    logic          w_accept;
    logic          w_word_done;
    logic          w_ovf;
    logic          w_wr_done;
    logic [31:0]   w_byte_shift;
    logic [31:0]   w_word;

    assign w_accept     = (r_state == S_LOAD) && bus.in_valid;
    assign w_word_done  = w_accept && ((r_lane == 2'd3) || bus.in_last);
    assign w_ovf        = (r_idx == c_DEPTH_IDX);
    assign w_wr_done    = (r_state == S_WRITE) && bus.mem_rdy;
    assign w_byte_shift = {24'd0, bus.in_data} << {r_lane, 3'b000};
    assign w_word       = r_word | w_byte_shift;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD: begin
                if (w_word_done) begin
                    if (!w_ovf) begin
                        w_next = S_WRITE;
                    end else if (bus.in_last) begin
                        w_next = S_DONE;
                    end
                end
            end
            S_WRITE: begin
                if (bus.mem_rdy) begin
                    w_next = r_last ? S_DONE : S_LOAD;
                end
            end
            S_DONE:  w_next = S_DONE;
            default: w_next = S_LOAD;
        endcase
    end

    // Handshake outputs are registered from the next state so they never glitch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_ready <= 1'b1;
            r_mem_wen  <= 1'b0;
            r_enable   <= 1'b0;
            r_lane     <= 2'd0;
            r_word     <= 32'd0;
            r_idx      <= '0;
            r_last     <= 1'b0;
            r_err      <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= 32'd0;
        end else begin
            r_in_ready <= (w_next == S_LOAD);
            r_mem_wen  <= (w_next == S_WRITE);
            r_enable   <= (w_next == S_DONE);

            if (w_word_done) begin
                r_lane <= 2'd0;
                r_word <= 32'd0;
                if (w_ovf) begin
                    r_err <= 1'b1;
                end else begin
                    r_mem_addr <= r_idx[AW-1:0];
                    r_mem_data <= w_word;
                    r_last     <= bus.in_last;
                end
            end else if (w_accept) begin
                r_lane <= r_lane + 2'd1;
                r_word <= w_word;
            end

            if (w_wr_done) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.mem_wen  = r_mem_wen;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_data = r_mem_data;
    assign bus.enable   = r_enable;
    assign bus.err      = r_err;

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [31:0] r_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum <= 32'd0;
        end else if (w_wr_done) begin
            r_sum <= r_sum + r_mem_data;
        end
    end

    assign bus.boot_sum = r_sum;
`else
    assign bus.boot_sum = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_boot_loader.sv
// ============================================================================
// Module  : tb_boot_loader
// Brief   : Scoreboard bench for boot_loader (DEPTH=2, AW=1 so the index
//           reaches 2^AW); expected writes are queued, a monitor pops them.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_boot_loader;

    logic clk;
    logic rst;

    boot_loader_if #(.AW(1)) bus ();

    boot_loader #(
        .DEPTH (2),
        .AW    (1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk;
    int          n_fail;
    int          cyc;
    int          hs_last;
    int          hs_prev;
    logic [32:0] exp_q[$];
    logic [31:0] exp_sum;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
`ifdef BOOT_LOADER_CHECKSUM_EN
        exp_sum = exp_sum + data;
`endif
    endtask

    // Monitor: every write handshake must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst && bus.mem_wen && bus.mem_rdy) begin
            logic [32:0] e;
            hs_prev = hs_last;
            hs_last = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {31'd0, bus.mem_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", {31'd0, bus.mem_addr}, {31'd0, e[32]});
                check("write_data", bus.mem_data, e[31:0]);
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic last);
        bit got;
        got = 1'b0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("byte_accepted", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic wait_enable(input string name, input bit check_hs);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.enable) break;
        end
        check({name, "_enable"}, {31'd0, bus.enable}, 32'd1);
        if (check_hs) check({name, "_enable_latency"}, cyc - hs_last, 32'd1);
        check({name, "_queue_drained"}, exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        #2;
        rst          = 1'b0;
        bus.mem_rdy  = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'h00;
        exp_sum      = 32'd0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v1 [8];
        logic       stall_ok;
        logic [0:0] a0;
        logic [31:0] d0;

        n_chk = 0; n_fail = 0; cyc = 0; hs_last = 0; hs_prev = 0;
        exp_sum = 32'd0;
        rst = 1'b1;
        bus.mem_rdy = 1'b1; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = 8'h00;

        // Reset state
        do_reset();
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_mem_wen",  {31'd0, bus.mem_wen},  32'd0);
        check("rst_enable",   {31'd0, bus.enable},   32'd0);
        check("rst_err",      {31'd0, bus.err},      32'd0);
        check("rst_boot_sum", bus.boot_sum,          32'd0);
        check("rst_mem_addr", {31'd0, bus.mem_addr}, 32'd0);
        check("rst_mem_data", bus.mem_data,          32'd0);

        // Two full words, zero-wait memory
        v1 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        push_exp(1'b0, 32'h1234_5678);
        push_exp(1'b1, 32'hDEAD_BEEF);
        for (int i = 0; i < 8; i++) send(v1[i], i == 7);
        wait_enable("two_words", 1'b1);
        check("two_words_throughput", hs_last - hs_prev, 32'd5);
        check("two_words_err", {31'd0, bus.err}, 32'd0);
        check("two_words_sum", bus.boot_sum, exp_sum);

        // Partial final word is zero-padded
        do_reset();
        push_exp(1'b0, 32'h0403_0201);
        push_exp(1'b1, 32'h0000_0005);
        for (int i = 1; i <= 5; i++) send(8'(i), i == 5);
        wait_enable("partial", 1'b1);

        // Memory stall in first WRITE
        do_reset();
        push_exp(1'b0, 32'h4433_2211);
        push_exp(1'b1, 32'h8877_6655);
        bus.mem_rdy = 1'b0;
        fork
            begin
                for (int i = 1; i <= 8; i++) send(8'(8'h11 * i), i == 8);
            end
            begin
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (bus.mem_wen) break;
                end
                a0 = bus.mem_addr;
                d0 = bus.mem_data;
                stall_ok = bus.mem_wen && !bus.in_ready;
                for (int k = 1; k < 4; k++) begin
                    if (k == 3) begin
                        @(posedge clk);
                        #1;
                        bus.mem_rdy = 1'b1;
                    end
                    @(negedge clk);
                    if (!bus.mem_wen || bus.in_ready || bus.mem_addr !== a0 || bus.mem_data !== d0)
                        stall_ok = 1'b0;
                end
                check("stall_outputs_stable", {31'd0, stall_ok}, 32'd1);
            end
        join
        wait_enable("stall", 1'b1);

        // Asynchronous reset in the middle of WRITE of word 1
        do_reset();
        push_exp(1'b0, 32'h0403_0201);
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
        bus.mem_rdy = 1'b0;
        for (int i = 6; i <= 8; i++) send(8'(i), 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.mem_wen) break;
        end
        check("mid_write_addr", {31'd0, bus.mem_addr}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_mem_wen", {31'd0, bus.mem_wen}, 32'd0);
        check("async_rst_queue_drained", exp_q.size(), 32'd0);
        do_reset();
        push_exp(1'b0, 32'hAAAA_AAAA);
        for (int i = 0; i < 4; i++) send(8'hAA, i == 3);
        wait_enable("after_rst", 1'b1);

        // Overflow beyond DEPTH=2 words
        do_reset();
        push_exp(1'b0, 32'h0403_0201);
        push_exp(1'b1, 32'h0807_0605);
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
        check("ovf_err_before", {31'd0, bus.err}, 32'd0);
        for (int i = 9; i <= 12; i++) send(8'(i), i == 12);
        wait_enable("overflow", 1'b0);
        check("ovf_err_after", {31'd0, bus.err}, 32'd1);
        check("ovf_sum", bus.boot_sum, exp_sum);

        // Checksum wrap: 0xFFFFFFFF + 0x00000002
        do_reset();
        push_exp(1'b0, 32'hFFFF_FFFF);
        push_exp(1'b1, 32'h0000_0002);
        for (int i = 0; i < 4; i++) send(8'hFF, 1'b0);
        send(8'h02, 1'b0);
        for (int i = 0; i < 3; i++) send(8'h00, i == 2);
        wait_enable("checksum", 1'b1);
`ifdef BOOT_LOADER_CHECKSUM_EN
        check("checksum_value", bus.boot_sum, 32'h0000_0001);
`else
        check("checksum_value", bus.boot_sum, 32'h0000_0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter DEPTH, default 4096: number of 32-bit words in the target memory bank; legal word addresses are 0..DEPTH-1.
REQ-002 Parameter AW, default 12: memory word-address width; DEPTH SHALL NOT exceed 2^AW.
REQ-003 clk  input  1  single system clock, all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  8  program-image byte, little-endian within each word.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_last  input  1  qualified by in_valid: the current byte is the final byte of the image.
REQ-008 in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-009 mem_addr  output  AW  word address of the current write.
REQ-010 mem_data  output  32  word to be written.
REQ-011 mem_wen  output  1  write request.
REQ-012 mem_rdy  input  1  memory has completed the write when sampled high with mem_wen high.
REQ-013 enable  output  1  CPU run enable, drives the control unit's enable input.
REQ-014 err  output  1  sticky image-overflow flag.
REQ-015 boot_sum  output  32  image checksum; see Configuration.

Function
REQ-016 The FSM SHALL have exactly three states: LOAD, WRITE and DONE.
REQ-017 In LOAD:
- in_ready=1, mem_wen=0.
- Each accepted byte goes to lane n, where n counts 0..3 from the start of the word; lane 0 is bits 7:0 and lane 3 is bits 31:24.
REQ-018 When lane 3 is accepted, or any byte with in_last=1 is accepted, the next cycle SHALL be WRITE.
REQ-019 On a final partial word, the unfilled upper lanes SHALL be zero.
REQ-020 In WRITE:
- in_ready=0, mem_wen=1.
- mem_addr = current word index; mem_data = the assembled word.
- All three outputs SHALL stay stable until mem_rdy is sampled high.
REQ-021 On the edge where WRITE sees mem_rdy=1:
- the word index increments;
- the lane counter and assembly register clear;
- the next state is DONE if the word was flagged last, otherwise LOAD.
REQ-022 A zero-wait memory (mem_rdy tied high) SHALL give a throughput of one word per 5 cycles: 4 LOAD cycles plus 1 WRITE cycle.
REQ-023 Overflow: if the word index equals DEPTH when a word completes:
- no write is issued and err is set;
- further bytes are accepted and discarded until in_last, then the FSM enters DONE.
REQ-024 In DONE:
- enable=1, in_ready=0, mem_wen=0;
- the FSM remains in DONE until reset.
REQ-025 enable SHALL be driven from a register (glitch-free) and SHALL rise exactly one cycle after the final write handshake.
REQ-026 in_data is ignored when in_valid=0; in_last is ignored when in_valid=0.

Reset
REQ-027 Asserting rst (low) SHALL asynchronously force the following, regardless of state:
- state=LOAD, word index=0, lane=0;
- mem_wen=0, enable=0, err=0, boot_sum=0, in_ready=1 after release.
REQ-028 A reset during WRITE SHALL drop mem_wen immediately; memory contents already written are not restored.
REQ-029 Outputs mem_addr and mem_data SHALL reset to 0.

Configuration
REQ-030 Macro BOOT_LOADER_CHECKSUM_EN defined:
- boot_sum accumulates the modulo-2^32 sum of every word actually written to memory;
- the sum updates on each write handshake.
REQ-031 Macro BOOT_LOADER_CHECKSUM_EN undefined:
- boot_sum SHALL be constant 0 and contain no adder logic;
- the port list is identical in both builds.

Verification
REQ-032 Send 8 bytes 0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE (last on the 8th), mem_rdy=1 -> writes addr0=0x12345678 and addr1=0xDEADBEEF; enable=1 one cycle after the second write; err=0.
REQ-033 Send 5 bytes 0x01..0x05 (last on 0x05) -> addr0=0x04030201, addr1=0x00000005; enable asserted.
REQ-034 mem_rdy held low 3 cycles in the first WRITE -> mem_wen, mem_addr and mem_data stay stable for 4 cycles; in_ready=0 throughout; no byte is lost.
REQ-035 DEPTH=2, send 12 bytes -> exactly 2 writes; err=1 after the third word completes; enable=1 after last.
REQ-036 Pull rst low mid-WRITE on word 1, release, resend 4 bytes 0xAA each -> mem_wen drops asynchronously; the new write goes to addr0 with data 0xAAAAAAAA.
REQ-037 With BOOT_LOADER_CHECKSUM_EN, image words 0xFFFFFFFF and 0x00000002 -> boot_sum=0x00000001; without the macro, boot_sum=0.
